// File: rtl/regload_sequencer_pkg.sv
// rtl/regload_sequencer_pkg.sv - shared state encoding for the register-load sequencer
// Purpose : FSM state type and state width used by regload_sequencer.
// Ports   : none (package).
package regload_sequencer_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_CLEAR    = 3'd1,
      ST_LOAD     = 3'd2,
      ST_HOLDOFF  = 3'd3,
      ST_WAIT_REL = 3'd4
   } state_e;

endpackage

// File: rtl/regload_sequencer_fall_edge.sv
// rtl/regload_sequencer_fall_edge.sv - falling-edge press detector for one debounced button
// Purpose : registers an active-low button and flags a one-cycle press on its falling edge.
// Ports   : clk        in   system clock, rising edge
//           rst_n      in   asynchronous active-low reset
//           btn_in_low in   debounced button, 0 = pressed
//           level_out  out  registered button level (1 = released)
//           press_out  out  high for one cycle after the registered level falls
module sc_fall_edge
   import regload_sequencer_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in_low,
   output logic level_out,
   output logic press_out
);

   logic sample_q, sample_d;
   logic delay_q,  delay_d;
   logic armed_q,  armed_d;

   // armed only sets once the raw button has been seen released after reset,
   // so a button held through reset never turns into a press when reset lifts.
   always_comb begin
      sample_d = btn_in_low;
      delay_d  = sample_q;
      armed_d  = armed_q | btn_in_low;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q <= 1'b1;
         delay_q  <= 1'b1;
         armed_q  <= 1'b0;
      end else begin
         sample_q <= sample_d;
         delay_q  <= delay_d;
         armed_q  <= armed_d;
      end
   end

   assign level_out = sample_q;
   assign press_out = delay_q & ~sample_q & armed_q;

endmodule

// File: rtl/regload_sequencer.sv
// rtl/regload_sequencer.sv - turns clear/load button presses into single register strobes
// Purpose : one press gives one active-low one-cycle strobe; clear wins over load;
//           hold-off and release wait between actions; counts accepted loads.
//           Optional macro REGSEQ_AUTOLOAD_EN adds a periodic automatic load from IDLE.
// Ports   : regload_sequencer_CLOCK_50         in   system clock, rising edge
//           regload_sequencer_RESET_InLow      in   asynchronous active-low reset
//           regload_sequencer_clear_InLow      in   debounced clear button, 0 = pressed
//           regload_sequencer_load_InLow       in   debounced load button, 0 = pressed
//           regload_sequencer_clear_OutLow     out  clear strobe, low for one cycle
//           regload_sequencer_load_OutLow      out  load strobe, low for one cycle
//           regload_sequencer_busy_Out         out  1 whenever the FSM is not IDLE
//           regload_sequencer_loadcount_OutBUS out  loads issued since last clear/reset
module regload_sequencer
   import regload_sequencer_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 4,
   parameter int CNT_WIDTH      = 8,
   parameter int AUTO_PERIOD    = 50000000,
   parameter int AUTO_CNT_WIDTH = 26
) (
   input  logic                 regload_sequencer_CLOCK_50,
   input  logic                 regload_sequencer_RESET_InLow,
   input  logic                 regload_sequencer_clear_InLow,
   input  logic                 regload_sequencer_load_InLow,
   output logic                 regload_sequencer_clear_OutLow,
   output logic                 regload_sequencer_load_OutLow,
   output logic                 regload_sequencer_busy_Out,
   output logic [CNT_WIDTH-1:0] regload_sequencer_loadcount_OutBUS
);

   localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

   if (HOLDOFF_CYCLES < 1) begin : g_chk_holdoff
      $error("HOLDOFF_CYCLES must be at least 1");
   end
   if ((AUTO_PERIOD < 1) || (AUTO_CNT_WIDTH < $clog2(AUTO_PERIOD))) begin : g_chk_auto
      $error("AUTO_CNT_WIDTH too narrow for AUTO_PERIOD");
   end

   logic clk, rst_n;
   assign clk   = regload_sequencer_CLOCK_50;
   assign rst_n = regload_sequencer_RESET_InLow;

   logic clr_level, clr_press;
   logic ld_level,  ld_press;

   sc_fall_edge u_clear_edge (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in_low (regload_sequencer_clear_InLow),
      .level_out  (clr_level),
      .press_out  (clr_press)
   );

   sc_fall_edge u_load_edge (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in_low (regload_sequencer_load_InLow),
      .level_out  (ld_level),
      .press_out  (ld_press)
   );

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
   logic [HOLD_W-1:0]     hold_q,  hold_d;
   logic                  clear_n_q, clear_n_d;
   logic                  load_n_q,  load_n_d;
   logic                  busy_q,    busy_d;

`ifdef REGSEQ_AUTOLOAD_EN
   localparam logic [AUTO_CNT_WIDTH-1:0] AUTO_LAST = AUTO_CNT_WIDTH'(AUTO_PERIOD - 1);
   logic [AUTO_CNT_WIDTH-1:0] timer_q, timer_d;
   logic                      auto_fire;
   assign auto_fire = (timer_q == AUTO_LAST);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_press)     state_d = ST_CLEAR;
            else if (ld_press) state_d = ST_LOAD;
`ifdef REGSEQ_AUTOLOAD_EN
            else if (auto_fire) state_d = ST_LOAD;
`endif
         end
         ST_CLEAR: begin
            cnt_d   = '0;
            hold_d  = HOLD_LOAD;
            state_d = ST_HOLDOFF;
         end
         ST_LOAD: begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            hold_d  = HOLD_LOAD;
            state_d = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            if (hold_q == '0) state_d = ST_WAIT_REL;
            else              hold_d  = hold_q - HOLD_W'(1);
         end
         ST_WAIT_REL: begin
            if (clr_level && ld_level) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so each strobe is low exactly
      // for the one cycle the FSM sits in CLEAR or LOAD.
      clear_n_d = (state_d != ST_CLEAR);
      load_n_d  = (state_d != ST_LOAD);
      busy_d    = (state_d != ST_IDLE);
   end

`ifdef REGSEQ_AUTOLOAD_EN
   // Timer advances only while the FSM stays in IDLE; any exit (press or auto
   // load) returns it to zero.
   always_comb begin
      timer_d = '0;
      if (state_q == ST_IDLE && state_d == ST_IDLE) timer_d = timer_q + AUTO_CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timer_q <= '0;
      else        timer_q <= timer_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hold_q    <= '0;
         clear_n_q <= 1'b1;
         load_n_q  <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         clear_n_q <= clear_n_d;
         load_n_q  <= load_n_d;
         busy_q    <= busy_d;
      end
   end

   assign regload_sequencer_clear_OutLow     = clear_n_q;
   assign regload_sequencer_load_OutLow      = load_n_q;
   assign regload_sequencer_busy_Out         = busy_q;
   assign regload_sequencer_loadcount_OutBUS = cnt_q;

endmodule

// File: tb/tb_regload_sequencer.sv
// tb/tb_regload_sequencer.sv - scoreboard bench for regload_sequencer
module tb_regload_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr_in = 1'b1;
   logic       ld_in = 1'b1;
   logic       clr_o, ld_o, busy_o;
   logic [7:0] cnt_o;

   regload_sequencer #(
      .HOLDOFF_CYCLES (4),
      .CNT_WIDTH      (8),
      .AUTO_PERIOD    (16),
      .AUTO_CNT_WIDTH (5)
   ) dut (
      .regload_sequencer_CLOCK_50         (clk),
      .regload_sequencer_RESET_InLow      (rst_n),
      .regload_sequencer_clear_InLow      (clr_in),
      .regload_sequencer_load_InLow       (ld_in),
      .regload_sequencer_clear_OutLow     (clr_o),
      .regload_sequencer_load_OutLow      (ld_o),
      .regload_sequencer_busy_Out         (busy_o),
      .regload_sequencer_loadcount_OutBUS (cnt_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      bit         is_clear;
      int         at_cyc;
      logic [7:0] cnt;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_cnt = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: strobe appears two edges after the button is driven at a negedge.
   task automatic expect_strobe(input bit is_clear, input int c0);
      exp_t e;
      if (is_clear) exp_cnt = 8'd0;
      else          exp_cnt = exp_cnt + 8'd1;
      e.is_clear = is_clear;
      e.at_cyc   = c0 + 2;
      e.cnt      = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic press(input bit c, input bit l, input int hold);
      int c0;
      c0 = cyc;
      expect_strobe(c, c0);
      clr_in = ~c;
      ld_in  = ~l;
      idle(hold);
      clr_in = 1'b1;
      ld_in  = 1'b1;
      idle(12);
   endtask

   // Monitor: pops one expectation per observed strobe cycle, then checks the
   // counter on the following cycle once the FSM has left CLEAR/LOAD.
   initial begin
      exp_t       e;
      bit         pend;
      logic [7:0] pend_cnt;
      pend = 1'b0;
      pend_cnt = 8'd0;
      forever begin
         @(negedge clk);
         if (pend) begin
            check("loadcount_after_strobe", 32'(cnt_o), 32'(pend_cnt));
            pend = 1'b0;
         end
         if (clr_o === 1'b0 || ld_o === 1'b0) begin
            check("strobes_not_both_low", 32'({clr_o, ld_o} == 2'b00), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe: clear=%0b load=%0b required none (cycle %0d)", clr_o, ld_o, cyc);
            end else begin
               e = sb.pop_front();
               check("strobe_kind", 32'({clr_o, ld_o}), e.is_clear ? 32'd1 : 32'd2);
               check("strobe_cycle", 32'(cyc), 32'(e.at_cyc));
               pend_cnt = e.cnt;
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0;
      int r;
`ifdef REGSEQ_AUTOLOAD_EN
      idle(3);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_load_n", 32'(ld_o), 32'd1);
      rst_n = 1'b1;
      r = cyc;
      expect_strobe(1'b0, r + 14);
      expect_strobe(1'b0, r + 36);
      idle(40);
      check("auto_busy_in_holdoff", 32'(busy_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("auto_reset_busy", 32'(busy_o), 32'd0);
      check("auto_reset_load_n", 32'(ld_o), 32'd1);
      check("auto_reset_cnt", 32'(cnt_o), 32'd0);
      idle(3);
`else
      // Load button held low through reset and after release: not a press.
      ld_in = 1'b0;
      idle(3);
      check("reset_clear_n", 32'(clr_o), 32'd1);
      check("reset_load_n", 32'(ld_o), 32'd1);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_cnt", 32'(cnt_o), 32'd0);
      rst_n = 1'b1;
      idle(10);
      check("held_through_reset_busy", 32'(busy_o), 32'd0);
      check("held_through_reset_cnt", 32'(cnt_o), 32'd0);
      ld_in = 1'b1;
      idle(5);

      // Single load held 10 cycles: busy through HOLDOFF and WAIT_REL.
      c0 = cyc;
      expect_strobe(1'b0, c0);
      ld_in = 1'b0;
      idle(5);
      check("busy_in_holdoff", 32'(busy_o), 32'd1);
      idle(5);
      check("busy_wait_release", 32'(busy_o), 32'd1);
      ld_in = 1'b1;
      for (int i = 0; i < 20 && busy_o; i++) idle(1);
      check("busy_drop_cycle", 32'(cyc), 32'(c0 + 12));
      check("cnt_after_first_load", 32'(cnt_o), 32'd1);
      idle(3);

      // Second press inside HOLDOFF is dropped.
      c0 = cyc;
      expect_strobe(1'b0, c0);
      ld_in = 1'b0;
      idle(1);
      ld_in = 1'b1;
      idle(2);
      ld_in = 1'b0;
      idle(1);
      ld_in = 1'b1;
      idle(12);
      check("cnt_holdoff_press_dropped", 32'(cnt_o), 32'd2);

      // Clear and load in the same cycle: clear only.
      press(1'b1, 1'b1, 3);
      check("cnt_after_both", 32'(cnt_o), 32'd0);

      // 256 loads wrap the 8-bit counter to zero, then a clear keeps it there.
      for (int i = 0; i < 256; i++) press(1'b0, 1'b1, 1);
      check("cnt_after_wrap", 32'(cnt_o), 32'd0);
      press(1'b1, 1'b0, 2);
      check("cnt_after_clear", 32'(cnt_o), 32'd0);

      // A load then reset asserted while the strobe is low.
      press(1'b0, 1'b1, 1);
      c0 = cyc;
      expect_strobe(1'b0, c0);
      sb[sb.size()-1].cnt = 8'd0;
      ld_in = 1'b0;
      idle(1);
      ld_in = 1'b1;
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      check("midstrobe_reset_load_n", 32'(ld_o), 32'd1);
      check("midstrobe_reset_busy", 32'(busy_o), 32'd0);
      idle(3);
      rst_n = 1'b1;
      exp_cnt = 8'd0;
      idle(5);
      check("after_reset_cnt", 32'(cnt_o), 32'd0);
`endif
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
